// File: rtl/pipe_trace_buffer.sv
// -----------------------------------------------------------------------------
// pipe_trace_buffer
//
// Captures one 512-bit writeback pipeReg snapshot per retired instruction,
// stamps it with a free-running cycle count and queues it in a circular FIFO.
// The FIFO drains over a valid/ready stream to the debug/trace monitor, so
// the core never waits on the monitor's print pacing.
//
// Optional feature macro: TRACE_STALL_EN
//   defined   : a RUN/HOLD stall FSM drives o_stall_req as back-pressure
//   undefined : o_stall_req is tied 0; a retire into a full FIFO is dropped
//               and counted
//
// Parameters
//   DEPTH         FIFO entries (power of 2, >= 4)
//   STALL_MARGIN  free entries at which stall is requested (< DEPTH/2)
//
// Ports
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_capture_en      global capture enable; retires ignored when 0
//   i_retire_valid    i_pipeReg holds a retiring instruction this cycle
//   i_pipeReg         writeback pipeReg bundle
//   i_clear           synchronous clear of FIFO, o_overflow, o_drop_count
//   o_Cycle_count     free-running cycle counter
//   o_trace_valid     head entry available
//   i_trace_ready     consumer accepts head entry
//   o_trace_pipeReg   head entry snapshot
//   o_trace_cycle     head entry cycle stamp
//   o_trace_pc        head entry PC field (pipeReg[`PC_reg])
//   o_level           entries held
//   o_overflow        sticky: at least one retire dropped
//   o_drop_count      dropped retires, saturating
//   o_stall_req       back-pressure request to the core
// -----------------------------------------------------------------------------

// PC field location inside the pipeReg bundle; integration may predefine it.
`ifndef PC_reg
`define PC_reg 31:0
`endif

module pipe_trace_buffer #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned STALL_MARGIN = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_capture_en,
    input  logic                     i_retire_valid,
    input  logic [511:0]             i_pipeReg,
    input  logic                     i_clear,
    output logic [31:0]              o_Cycle_count,
    output logic                     o_trace_valid,
    input  logic                     i_trace_ready,
    output logic [511:0]             o_trace_pipeReg,
    output logic [31:0]              o_trace_cycle,
    output logic [31:0]              o_trace_pc,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic [15:0]              o_drop_count,
    output logic                     o_stall_req
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || STALL_MARGIN >= DEPTH / 2) begin : g_bad_params
        $error("pipe_trace_buffer: DEPTH must be a power of 2 >= 4 and STALL_MARGIN < DEPTH/2");
    end

    // Payload storage: not reset, only meaningful while an entry is valid.
    logic [511:0] mem_data  [DEPTH];
    logic [31:0]  mem_stamp [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [31:0]   cycle_q;
    logic          overflow_q;
    logic [15:0]   drop_q;

    logic push;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    assign push    = i_retire_valid & i_capture_en;
    assign pop     = o_trace_valid & i_trace_ready;
    assign full    = (level == LEVEL_FULL);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    // Free-running stamp counter; i_clear deliberately does not touch it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (i_clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push_ok) begin
                level <= level - 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok && !i_clear) begin
            mem_data[wr_ptr]  <= i_pipeReg;
            mem_stamp[wr_ptr] <= cycle_q;
        end
    end

    // Show-ahead head outputs straight from storage at rd_ptr.
    assign o_Cycle_count   = cycle_q;
    assign o_level         = level;
    assign o_trace_valid   = (level != '0);
    assign o_trace_pipeReg = mem_data[rd_ptr];
    assign o_trace_cycle   = mem_stamp[rd_ptr];
    assign o_trace_pc      = mem_data[rd_ptr][`PC_reg];
    assign o_overflow      = overflow_q;
    assign o_drop_count    = drop_q;

`ifdef TRACE_STALL_EN
    localparam logic [LW-1:0] LEVEL_HOLD_ON  = LW'(DEPTH - STALL_MARGIN);
    localparam logic [LW-1:0] LEVEL_HOLD_OFF = LW'(DEPTH / 2);

    typedef enum logic {
        ST_RUN,
        ST_HOLD
    } stall_state_t;

    stall_state_t state;
    stall_state_t state_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Hysteresis between DEPTH-STALL_MARGIN and DEPTH/2; clear releases HOLD.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (!i_clear && level >= LEVEL_HOLD_ON) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_clear || level <= LEVEL_HOLD_OFF) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign o_stall_req = (state == ST_HOLD);
`else
    assign o_stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_trace_buffer
//
// Directed bench for pipe_trace_buffer. A queue-based reference model tracks
// the expected FIFO contents, cycle counter and status flags; a compare
// process checks every DUT output against it on each falling edge, and the
// directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_trace_buffer;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned MARGIN = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_capture_en = 1'b1;
    logic           i_retire_valid = 1'b0;
    logic [511:0]   i_pipeReg = '0;
    logic           i_clear = 1'b0;
    logic           i_trace_ready = 1'b0;
    logic [31:0]    o_Cycle_count;
    logic           o_trace_valid;
    logic [511:0]   o_trace_pipeReg;
    logic [31:0]    o_trace_cycle;
    logic [31:0]    o_trace_pc;
    logic [4:0]     o_level;
    logic           o_overflow;
    logic [15:0]    o_drop_count;
    logic           o_stall_req;

    pipe_trace_buffer #(
        .DEPTH        (DEPTH),
        .STALL_MARGIN (MARGIN)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_capture_en    (i_capture_en),
        .i_retire_valid  (i_retire_valid),
        .i_pipeReg       (i_pipeReg),
        .i_clear         (i_clear),
        .o_Cycle_count   (o_Cycle_count),
        .o_trace_valid   (o_trace_valid),
        .i_trace_ready   (i_trace_ready),
        .o_trace_pipeReg (o_trace_pipeReg),
        .o_trace_cycle   (o_trace_cycle),
        .o_trace_pc      (o_trace_pc),
        .o_level         (o_level),
        .o_overflow      (o_overflow),
        .o_drop_count    (o_drop_count),
        .o_stall_req     (o_stall_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [511:0] data;
        logic [31:0]  stamp;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_cyc   = '0;
    logic        m_ovf   = 1'b0;
    logic [15:0] m_drops = '0;
    logic        m_stall = 1'b0;

    task automatic model_step();
        int   sz;
        logic do_pop;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_cyc   = '0;
            m_ovf   = 1'b0;
            m_drops = '0;
            m_stall = 1'b0;
        end else begin
            sz = mq.size();
`ifdef TRACE_STALL_EN
            if (m_stall) begin
                if (i_clear || sz <= int'(DEPTH / 2)) m_stall = 1'b0;
            end else if (!i_clear && sz >= int'(DEPTH - MARGIN)) begin
                m_stall = 1'b1;
            end
`endif
            if (i_clear) begin
                mq.delete();
                m_ovf   = 1'b0;
                m_drops = '0;
            end else begin
                do_pop = (sz != 0) && i_trace_ready;
                if (do_pop) void'(mq.pop_front());
                if (i_retire_valid && i_capture_en) begin
                    if (sz == int'(DEPTH) && !do_pop) begin
                        m_ovf = 1'b1;
                        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                    end else begin
                        e.data  = i_pipeReg;
                        e.stamp = m_cyc;
                        mq.push_back(e);
                    end
                end
            end
            m_cyc = m_cyc + 32'd1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cycle_count", o_Cycle_count, m_cyc);
        chk("trace_valid", o_trace_valid, mq.size() != 0);
        chk("level", o_level, mq.size());
        chk("overflow", o_overflow, m_ovf);
        chk("drop_count", o_drop_count, m_drops);
        chk("stall_req", o_stall_req, m_stall);
        if (mq.size() != 0) begin
            chk("trace_pipeReg", o_trace_pipeReg, mq[0].data);
            chk("trace_cycle", o_trace_cycle, mq[0].stamp);
            chk("trace_pc", o_trace_pc, mq[0].data[31:0]);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] seq     = '0;
    logic [31:0] next_pc = 32'h0000_1000;

    task automatic step(input logic rv, input logic rdy, input logic clr, input logic ce = 1'b1);
        i_retire_valid = rv;
        i_trace_ready  = rdy;
        i_clear        = clr;
        i_capture_en   = ce;
        i_pipeReg      = {{15{32'hC0DE_0000 | seq}}, next_pc};
        if (rv) begin
            seq     = seq + 32'd1;
            next_pc = next_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] s0;
        logic [31:0] pc0;
        logic [4:0]  lvl_prev;
        int          n;

        // Reset state
        @(negedge clk);
        chk("rst_cycle", o_Cycle_count, 32'd0);
        chk("rst_valid", o_trace_valid, 1'b0);
        chk("rst_level", o_level, 5'd0);
        chk("rst_stall", o_stall_req, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cycle_after_rst", o_Cycle_count, 32'd1);

        // Single push at Cycle_count 10, PC 0x80
        n = 0;
        while (m_cyc != 32'd10 && n < 50) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("cycle_is_10", o_Cycle_count, 32'd10);
        next_pc = 32'h80;
        step(1'b1, 1'b0, 1'b0);
        chk("single_valid", o_trace_valid, 1'b1);
        chk("single_cycle", o_trace_cycle, 32'd10);
        chk("single_pc", o_trace_pc, 32'h80);
        chk("single_level", o_level, 5'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("single_pop_level", o_level, 5'd0);
        chk("single_pop_valid", o_trace_valid, 1'b0);

        // Reset mid-stream with 5 entries queued
        repeat (5) step(1'b1, 1'b0, 1'b0);
        chk("mid_level5", o_level, 5'd5);
        i_retire_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_cycle", o_Cycle_count, 32'd0);
        chk("mid_rst_level", o_level, 5'd0);
        chk("mid_rst_valid", o_trace_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_cycle1", o_Cycle_count, 32'd1);
        @(negedge clk);
        chk("mid_cycle2", o_Cycle_count, 32'd2);

        // Overflow: 20 pushes with ready low
        s0  = m_cyc;
        pc0 = next_pc;
        repeat (20) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);       // capture disabled: not a drop
        chk("ovf_level", o_level, 5'd16);
        chk("ovf_flag", o_overflow, 1'b1);
        chk("ovf_drops", o_drop_count, 16'd4);
        for (int i = 0; i < 16; i++) begin
            chk("drain_stamp", o_trace_cycle, s0 + 32'(i));
            chk("drain_pc", o_trace_pc, pc0 + 32'(4 * i));
            step(1'b0, 1'b1, 1'b0);
        end
        chk("drain_level", o_level, 5'd0);

        // Full with push and pop together
        repeat (16) step(1'b1, 1'b0, 1'b0);
        chk("full_level", o_level, 5'd16);
        repeat (8) step(1'b1, 1'b1, 1'b0);
        chk("pp_level", o_level, 5'd16);
        chk("pp_drops", o_drop_count, 16'd4);

        // Clear together with a push at level 7
        repeat (9) step(1'b0, 1'b1, 1'b0);
        chk("pre_clear_level", o_level, 5'd7);
        step(1'b1, 1'b0, 1'b1);
        chk("clr_level", o_level, 5'd0);
        chk("clr_valid", o_trace_valid, 1'b0);
        chk("clr_drops", o_drop_count, 16'd0);
        chk("clr_ovf", o_overflow, 1'b0);

        // Counter wrap
        step(1'b0, 1'b0, 1'b0);
        #1;
        force dut.cycle_q = 32'hFFFF_FFFE;
        m_cyc = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk("wrap_stamp0", o_trace_cycle, 32'hFFFF_FFFE);
        step(1'b0, 1'b1, 1'b0);
        chk("wrap_stamp1", o_trace_cycle, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 1'b0);
        chk("wrap_stamp2", o_trace_cycle, 32'h0000_0000);
        step(1'b0, 1'b1, 1'b0);
        chk("wrap_level", o_level, 5'd0);

`ifdef TRACE_STALL_EN
        // Compliant core: retire only while no stall is requested
        lvl_prev = '0;
        n = 0;
        while (!o_stall_req && n < 40) begin
            lvl_prev = o_level;
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("stall_rose", o_stall_req, 1'b1);
        chk("stall_rise_level", lvl_prev, 5'd14);
        n = 0;
        while (o_stall_req && n < 40) begin
            lvl_prev = o_level;
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
        chk("stall_fell", o_stall_req, 1'b0);
        chk("stall_fall_level", lvl_prev, 5'd8);
        chk("stall_no_drops", o_drop_count, 16'd0);
        repeat (8) step(1'b0, 1'b1, 1'b0);
        chk("stall_drained", o_level, 5'd0);
`else
        lvl_prev = '0;
        n = 0;
        repeat (16) step(1'b1, 1'b0, 1'b0);
        chk("nostall_full", o_stall_req, 1'b0);
        repeat (16) step(1'b0, 1'b1, 1'b0);
        chk("nostall_drained", o_level, 5'd0);
`endif

        step(1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
